// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: access size decoded from funct3 and FSM states.
package dbus_responder_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'b000,
    MEM_HALF   = 3'b001,
    MEM_WORD   = 3'b010,
    MEM_BYTE_U = 3'b100,
    MEM_HALF_U = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_BUSY = 2'd1,
    RSP_DONE = 2'd2
  } responder_state_t;

  // Stores only have signed-size encodings; LBU/LHU codes are load-only.
  function automatic logic size_legal(input mem_size_t size, input logic is_store);
    logic ok;
    case (size)
      MEM_BYTE, MEM_HALF, MEM_WORD: ok = 1'b1;
      MEM_BYTE_U, MEM_HALF_U:       ok = !is_store;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Combinational RV32I byte-lane steering: store byte enables/replication, load lane select
// with sign/zero extension, and a misalignment flag.
module dbus_lane_align
  import dbus_responder_pkg::*;
(
  input  logic [2:0]      f3_i,
  input  logic            we_i,
  input  logic [1:0]      offs_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            size_ok_o,
  output logic            misalign_o
);

  mem_size_t   size;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    size       = mem_size_t'(f3_i);
    rbyte      = rword_i[{offs_i, 3'b000} +: 8];
    // Halves only look at offs_i[1]; a set offs_i[0] is reported via misalign_o.
    rhalf      = offs_i[1] ? rword_i[31:16] : rword_i[15:0];
    be_o       = 4'b0000;
    wdata_o    = '0;
    rdata_o    = '0;
    size_ok_o  = size_legal(size, we_i);
    misalign_o = 1'b0;
    case (size)
      MEM_BYTE, MEM_BYTE_U: begin
        be_o    = 4'b0001 << offs_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (size == MEM_BYTE) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      MEM_HALF, MEM_HALF_U: begin
        be_o       = offs_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (size == MEM_HALF) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
        misalign_o = offs_i[0];
      end
      MEM_WORD: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
        misalign_o = |offs_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM with WAIT_STATES stall cycles per access and RV32I lane handling.
// Define DBUS_ERR_EN to flag misaligned accesses on err (write suppressed, rdata 0).
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       f3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata,
  output logic             stall,
  output logic             err,
  output responder_state_t dbg_state_o
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam bit          ZERO_LAT   = (WAIT_STATES == 0);
  // With 0 or 1 wait states the accept cycle alone covers the stall, so BUSY is skipped.
  localparam bit          SHORT_WAIT = (WAIT_STATES <= 1);
  localparam logic [3:0]  CNT_INIT   = SHORT_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  responder_state_t state_q;
  logic [3:0]       cnt_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [2:0]       f3_q;
  logic             we_q;

  logic [XLEN-1:0]  mem [DEPTH];

  logic [XLEN-1:0]  cur_addr;
  logic [XLEN-1:0]  cur_wdata;
  logic [2:0]       cur_f3;
  logic             cur_we;
  logic             complete;
  logic [AW-1:0]    word_idx;
  logic [XLEN-1:0]  rword;

  logic [3:0]       be;
  logic [XLEN-1:0]  wdata_rep;
  logic [XLEN-1:0]  rdata_ext;
  logic             size_ok;
  logic             misalign;
  logic             bad;
  logic             wr_en;

  // BUSY runs WAIT_STATES-1 cycles; together with the accept cycle stall is high WAIT_STATES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        RSP_IDLE: begin
          if (req) begin
            cnt_q   <= CNT_INIT;
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= f3;
            we_q    <= we;
            state_q <= SHORT_WAIT ? RSP_DONE : RSP_BUSY;
          end
        end
        RSP_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= RSP_DONE;
        end
        RSP_DONE: state_q <= RSP_IDLE;
        default:  state_q <= RSP_IDLE;
      endcase
    end
  end

  // Zero-latency accesses complete in the accept cycle straight from the request inputs.
  always_comb begin
    if (ZERO_LAT) begin
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_f3    = f3;
      cur_we    = we;
      complete  = (state_q == RSP_IDLE) && req;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = f3_q;
      cur_we    = we_q;
      complete  = (state_q == RSP_DONE);
    end
    complete = complete && !rst;
  end

  assign word_idx = cur_addr[2 +: AW];
  assign rword    = mem[word_idx];

  dbus_lane_align u_align (
    .f3_i       (cur_f3),
    .we_i       (cur_we),
    .offs_i     (cur_addr[1:0]),
    .wdata_i    (cur_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (rdata_ext),
    .size_ok_o  (size_ok),
    .misalign_o (misalign)
  );

`ifdef DBUS_ERR_EN
  assign bad = misalign;
  assign err = complete && misalign;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  assign wr_en       = complete && cur_we && size_ok && !bad;
  assign rdata       = (complete && size_ok && !bad) ? rdata_ext : '0;
  assign stall       = !rst && (((state_q == RSP_IDLE) && req && !ZERO_LAT) || (state_q == RSP_BUSY));
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (complete) begin
      assert (size_ok)
      else $error("dbus_responder: unsupported f3=%b for we=%b", cur_f3, cur_we);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cur_addr[XLEN-1:AW+2], misalign};

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: one instance with WAIT_STATES=2 and one with WAIT_STATES=0,
// directed and random load/store traffic against a word-level shadow memory.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req_a, we_a, stall_a, err_a;
  logic [2:0]       f3_a;
  logic [31:0]      addr_a, wdata_a, rdata_a;
  responder_state_t st_a;

  logic             req_z, we_z, stall_z, err_z;
  logic [2:0]       f3_z;
  logic [31:0]      addr_z, wdata_z, rdata_z;
  responder_state_t st_z;

  dbus_responder #(.DEPTH(1024), .WAIT_STATES(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .f3(f3_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .stall(stall_a), .err(err_a), .dbg_state_o(st_a)
  );

  dbus_responder #(.DEPTH(1024), .WAIT_STATES(0), .INIT_FILE("")) u_dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we_z), .f3(f3_z), .addr(addr_z), .wdata(wdata_z),
    .rdata(rdata_z), .stall(stall_z), .err(err_z), .dbg_state_o(st_z)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] shadow [0:1023];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] w, input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * o));
    h = 16'(w >> (o[1] ? 16 : 0));
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f, input logic [1:0] o,
                                              input logic [31:0] d);
    logic [31:0] mask;
    case (f)
      3'b000: begin
        mask = 32'h0000_00FF << (8 * o);
        return (w & ~mask) | ((d & 32'h0000_00FF) << (8 * o));
      end
      3'b001: begin
        mask = 32'h0000_FFFF << (o[1] ? 16 : 0);
        return (w & ~mask) | ((d & 32'h0000_FFFF) << (o[1] ? 16 : 0));
      end
      3'b010:  return d;
      default: return w;
    endcase
  endfunction

  function automatic logic exp_misalign(input logic [2:0] f, input logic [31:0] a);
`ifdef DBUS_ERR_EN
    return ((f == 3'b001 || f == 3'b101) && a[0]) || (f == 3'b010 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic access_a(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int   idx;
    logic mis;
    int   stall_cyc;
    bit   done;
    idx = int'(a[11:2]);
    mis = exp_misalign(f, a);
    if (!w) exp_q.push_back(mis ? 32'd0 : model_load(f, shadow[idx], a[1:0]));
    @(posedge clk); #1;
    req_a = 1'b1; we_a = w; f3_a = f; addr_a = a; wdata_a = d;
    stall_cyc = 0;
    done      = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall_a) begin
        stall_cyc++;
        if (stall_cyc == 1) check_eq("rdata_during_stall", rdata_a, 32'd0);
      end else begin
        done = 1'b1;
      end
    end
    check_eq("stall_cycles", stall_cyc, 32'd2);
    check_eq("done_state", st_a, RSP_DONE);
    check_eq("err", err_a, mis);
    if (!w) check_eq("load_data", rdata_a, exp_q.pop_front());
    else if (!mis) shadow[idx] = model_store(shadow[idx], f, a[1:0], d);
    @(posedge clk); #1;
    req_a = 1'b0;
    @(negedge clk);
    check_eq("stall_after", stall_a, 32'd0);
    check_eq("err_after", err_a, 32'd0);
  endtask

  task automatic access_z(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int   idx;
    logic mis;
    idx = int'(a[11:2]);
    mis = exp_misalign(f, a);
    if (!w) exp_q.push_back(mis ? 32'd0 : model_load(f, shadow[idx], a[1:0]));
    @(posedge clk); #1;
    req_z = 1'b1; we_z = w; f3_z = f; addr_z = a; wdata_z = d;
    @(negedge clk);
    check_eq("z_stall", stall_z, 32'd0);
    check_eq("z_err", err_z, mis);
    if (!w) check_eq("z_load_data", rdata_z, exp_q.pop_front());
    else if (!mis) shadow[idx] = model_store(shadow[idx], f, a[1:0], d);
    @(negedge clk);
    check_eq("z_done_state", st_z, RSP_DONE);
    check_eq("z_done_rdata", rdata_z, 32'd0);
    check_eq("z_done_stall", stall_z, 32'd0);
    @(posedge clk); #1;
    req_z = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f_tab [5];
    logic [2:0]  f;
    logic [1:0]  offs;
    logic        w;
    logic [31:0] a;
    f_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset held with requests pending on both instances.
    rst = 1'b1;
    req_a = 1'b1; we_a = 1'b0; f3_a = 3'b010; addr_a = 32'h0; wdata_a = 32'h0;
    req_z = 1'b1; we_z = 1'b0; f3_z = 3'b010; addr_z = 32'h0; wdata_z = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_stall_a", stall_a, 32'd0);
    check_eq("rst_rdata_a", rdata_a, 32'd0);
    check_eq("rst_err_a", err_a, 32'd0);
    check_eq("rst_rdata_z", rdata_z, 32'd0);
    check_eq("rst_state_a", st_a, RSP_IDLE);
    @(posedge clk); #1;
    rst = 1'b0; req_a = 1'b0; req_z = 1'b0;
    @(negedge clk);
    check_eq("idle_state_a", st_a, RSP_IDLE);
    check_eq("idle_stall_a", stall_a, 32'd0);

    access_a(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    access_a(1'b0, 3'b010, 32'h10, 32'h0);

    access_a(1'b1, 3'b010, 32'h20, 32'h8000_00FF);
    access_a(1'b0, 3'b000, 32'h20, 32'h0);
    access_a(1'b0, 3'b100, 32'h20, 32'h0);
    access_a(1'b0, 3'b001, 32'h22, 32'h0);
    access_a(1'b0, 3'b101, 32'h22, 32'h0);

    access_a(1'b1, 3'b010, 32'h30, 32'h1122_3344);
    access_a(1'b1, 3'b000, 32'h31, 32'h0000_00AB);
    access_a(1'b0, 3'b010, 32'h30, 32'h0);
    access_a(1'b1, 3'b001, 32'h32, 32'h0000_BEEF);
    access_a(1'b0, 3'b010, 32'h30, 32'h0);

    access_a(1'b1, 3'b010, 32'h0, 32'h0BAD_F00D);
    access_a(1'b0, 3'b010, 32'h1000, 32'h0);

    // Reset while a store is in BUSY: no write, stall drops immediately.
    access_a(1'b1, 3'b010, 32'h50, 32'h0123_4567);
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b1; f3_a = 3'b010; addr_a = 32'h50; wdata_a = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check_eq("busy_state", st_a, RSP_BUSY);
    check_eq("busy_stall", stall_a, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_stall", stall_a, 32'd0);
    check_eq("rst_mid_rdata", rdata_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_a = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_state", st_a, RSP_IDLE);
    access_a(1'b0, 3'b010, 32'h50, 32'h0);

    access_a(1'b1, 3'b010, 32'h40, 32'h9988_7766);
    access_a(1'b1, 3'b010, 32'h42, 32'hCAFE_F00D);
    access_a(1'b0, 3'b010, 32'h40, 32'h0);
    access_a(1'b0, 3'b001, 32'h41, 32'h0);

    for (int i = 0; i < 8; i++) access_a(1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 24; i++) begin
      f = f_tab[$urandom_range(0, 4)];
      case (f)
        3'b000, 3'b100: offs = 2'($urandom_range(0, 3));
        3'b001, 3'b101: offs = {1'($urandom_range(0, 1)), 1'b0};
        default:        offs = 2'b00;
      endcase
      w = (f <= 3'b010) && ($urandom_range(0, 1) == 1);
      a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + {30'd0, offs};
      access_a(w, f, a, $urandom);
    end

    // Zero-latency instance, addresses disjoint from the other instance's traffic.
    access_z(1'b1, 3'b010, 32'h800, 32'hA5A5_5A5A);
    access_z(1'b0, 3'b010, 32'h800, 32'h0);
    access_z(1'b1, 3'b000, 32'h803, 32'h0000_007E);
    access_z(1'b0, 3'b000, 32'h803, 32'h0);
    access_z(1'b0, 3'b101, 32'h802, 32'h0);
    access_z(1'b1, 3'b001, 32'h800, 32'h0000_8001);
    access_z(1'b0, 3'b001, 32'h800, 32'h0);
    access_z(1'b0, 3'b010, 32'h800, 32'h0);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
